// File: rtl/regfile_wb_sequencer_if.sv
// Write-back sequencer bus: producer handshake, register-file write ports,
// hazard query and drop statistics bundled as one interface.
interface regfile_wb_sequencer_if;

   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        rf_stall;
   logic [4:0]  reg_addr1;
   logic [4:0]  reg_addr2;
   logic [31:0] wr_data1;
   logic [31:0] wr_data2;
   logic [1:0]  rdwr_config;
   logic [4:0]  query_addr;
   logic        query_hit;
   logic [7:0]  x0_drop_cnt;

   // Producer / register-file side: drives results, stall and hazard queries.
   modport master (
      output in_valid,
      output in_addr,
      output in_data,
      output rf_stall,
      output query_addr,
      input  in_ready,
      input  reg_addr1,
      input  reg_addr2,
      input  wr_data1,
      input  wr_data2,
      input  rdwr_config,
      input  query_hit,
      input  x0_drop_cnt
   );

   // Sequencer side: accepts results and issues register-file writes.
   modport slave (
      input  in_valid,
      input  in_addr,
      input  in_data,
      input  rf_stall,
      input  query_addr,
      output in_ready,
      output reg_addr1,
      output reg_addr2,
      output wr_data1,
      output wr_data2,
      output rdwr_config,
      output query_hit,
      output x0_drop_cnt
   );

endinterface

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer: buffers {addr, data} results in a small circular
// FIFO and drains them into a two-port register file, issuing two entries
// per cycle when their destinations differ. Writes to x0 are swallowed and
// counted. A hazard query reports whether a still-buffered entry targets
// a given register.
module regfile_wb_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_sequencer_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // FIFO storage and bookkeeping
   logic [4:0]       mem_addr [DEPTH];
   logic [31:0]      mem_data [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_plus1;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] issue_cnt;
   logic [PTR_W-1:0] slot_offset [DEPTH];

   // Handshake and drain decisions
   logic ready;
   logic accept;
   logic store;
   logic drop;
   logic issue_one;
   logic issue_two;
   logic hit;

   // Registered write-port outputs and drop statistics
   logic [4:0]  addr1_q;
   logic [4:0]  addr2_q;
   logic [31:0] data1_q;
   logic [31:0] data2_q;
   logic [1:0]  config_q;
   logic [7:0]  drop_cnt_q;

   // Readiness depends only on registered occupancy, so a full FIFO refuses
   // input even when it is draining in the same cycle.
   always_comb begin
      ready  = !rst && (count < DEPTH_C);
      accept = bus.in_valid && ready;
      store  = accept && (bus.in_addr != 5'd0);
      drop   = accept && (bus.in_addr == 5'd0);
   end

   // Choose how many entries leave the head this cycle; a same-address pair
   // is split across cycles so the older write cannot overtake the newer.
   always_comb begin
      head_plus1 = head + PTR_W'(1);
      issue_one  = 1'b0;
      issue_two  = 1'b0;
      if (!rst && !bus.rf_stall) begin
         if ((count >= CNT_W'(2)) && (mem_addr[head] != mem_addr[head_plus1])) begin
            issue_two = 1'b1;
         end else if (count != '0) begin
            issue_one = 1'b1;
         end
      end
   end

   // Translate the issue decision into a count and derive next occupancy.
   always_comb begin
      issue_cnt = '0;
      if (issue_two) begin
         issue_cnt = CNT_W'(2);
      end else if (issue_one) begin
         issue_cnt = CNT_W'(1);
      end
      count_next = count + CNT_W'(store) - issue_cnt;
   end

   // Pointer and occupancy registers; reset abandons anything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(issue_cnt);
         count <= count_next;
         if (store) begin
            tail <= tail + PTR_W'(1);
         end
      end
   end

   // Entry storage; only valid slots are ever observed, so no reset needed.
   always_ff @(posedge clk) begin
      if (store) begin
         mem_addr[tail] <= bus.in_addr;
         mem_data[tail] <= bus.in_data;
      end
   end

   // Saturating count of results discarded because they target x0.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= 8'd0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   // Register the issued entries onto the write ports; idle cycles only
   // clear the enables and leave address/data where they were.
   always_ff @(posedge clk) begin
      if (rst) begin
         config_q <= 2'b00;
         addr1_q  <= 5'd0;
         addr2_q  <= 5'd0;
         data1_q  <= 32'd0;
         data2_q  <= 32'd0;
      end else begin
         config_q <= {issue_two, issue_one | issue_two};
         if (issue_one || issue_two) begin
            addr1_q <= mem_addr[head];
            data1_q <= mem_data[head];
         end
         if (issue_two) begin
            addr2_q <= mem_addr[head_plus1];
            data2_q <= mem_data[head_plus1];
         end
      end
   end

   // Distance of every physical slot from the head, used to tell live,
   // leaving and empty slots apart.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_offset[i] = PTR_W'(i) - head;
      end
   end

   // Hazard lookup over entries that remain buffered after this cycle's issue.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(slot_offset[i]) < count) &&
             (CNT_W'(slot_offset[i]) >= issue_cnt) &&
             (mem_addr[i] == bus.query_addr)) begin
            hit = 1'b1;
         end
      end
      if (bus.query_addr == 5'd0) begin
         hit = 1'b0;
      end
   end

   // Drive the interface outputs from internal state.
   always_comb begin
      bus.in_ready    = ready;
      bus.query_hit   = hit;
      bus.rdwr_config = config_q;
      bus.reg_addr1   = addr1_q;
      bus.reg_addr2   = addr2_q;
      bus.wr_data1    = data1_q;
      bus.wr_data2    = data2_q;
      bus.x0_drop_cnt = drop_cnt_q;
   end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Testbench for regfile_wb_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_regfile_wb_sequencer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } entry_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   entry_t      model_q [$];
   logic [1:0]  exp_cfg;
   logic [4:0]  exp_a1;
   logic [4:0]  exp_a2;
   logic [31:0] exp_d1;
   logic [31:0] exp_d2;
   int          exp_drop;

   regfile_wb_sequencer_if bus ();

   regfile_wb_sequencer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs against the
   // model, advance the model across the clock edge and check registered outputs.
   task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                                input logic s, input logic [4:0] qa, input logic r);
      int     n_issue;
      logic   exp_rdy;
      logic   exp_hit;
      logic   acc;
      entry_t e;
      rst          = r;
      bus.in_valid = v;
      bus.in_addr  = a;
      bus.in_data  = d;
      bus.rf_stall = s;
      bus.query_addr = qa;
      #1;
      exp_rdy = !r && (model_q.size() < DEPTH);
      n_issue = 0;
      if (!r && !s) begin
         if (model_q.size() >= 2 && model_q[0].addr != model_q[1].addr) n_issue = 2;
         else if (model_q.size() >= 1) n_issue = 1;
      end
      exp_hit = 1'b0;
      for (int k = n_issue; k < model_q.size(); k++) begin
         if (qa != 5'd0 && model_q[k].addr == qa) exp_hit = 1'b1;
      end
      checkOutput("in_ready", bus.in_ready, exp_rdy);
      if (!r) checkOutput("query_hit", bus.query_hit, exp_hit);
      acc = v && exp_rdy;
      @(posedge clk);
      #1;
      if (r) begin
         model_q.delete();
         exp_drop = 0;
         exp_cfg  = 2'b00;
         exp_a1   = '0;
         exp_a2   = '0;
         exp_d1   = '0;
         exp_d2   = '0;
      end else begin
         exp_cfg = 2'b00;
         if (n_issue >= 1) begin
            e = model_q.pop_front();
            exp_a1 = e.addr;
            exp_d1 = e.data;
            exp_cfg = 2'b01;
         end
         if (n_issue == 2) begin
            e = model_q.pop_front();
            exp_a2 = e.addr;
            exp_d2 = e.data;
            exp_cfg = 2'b11;
         end
         if (acc) begin
            if (a == 5'd0) begin
               if (exp_drop < 255) exp_drop++;
            end else begin
               model_q.push_back('{addr: a, data: d});
            end
         end
      end
      checkOutput("rdwr_config", bus.rdwr_config, exp_cfg);
      checkOutput("reg_addr1", bus.reg_addr1, exp_a1);
      checkOutput("wr_data1", bus.wr_data1, exp_d1);
      if (r || n_issue == 2) begin
         checkOutput("reg_addr2", bus.reg_addr2, exp_a2);
         checkOutput("wr_data2", bus.wr_data2, exp_d2);
      end
      checkOutput("x0_drop_cnt", bus.x0_drop_cnt, exp_drop);
   endtask

   // Idle cycles with the register file open, letting the FIFO empty.
   task automatic drainIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Directed scenarios, then randomized traffic
   initial begin
      total    = 0;
      bad      = 0;
      exp_drop = 0;
      exp_cfg  = 2'b00;
      exp_a1   = '0;
      exp_a2   = '0;
      exp_d1   = '0;
      exp_d2   = '0;

      // Reset and come out of it
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      checkOutput("reset_cfg", bus.rdwr_config, 2'b00);
      checkOutput("reset_drop", bus.x0_drop_cnt, 8'd0);
      drainIdle(1);

      // Single write with two-cycle latency
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b0);
      checkOutput("single_cfg", bus.rdwr_config, 2'b01);
      checkOutput("single_addr", bus.reg_addr1, 5'd5);
      checkOutput("single_data", bus.wr_data1, 32'hDEADBEEF);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      checkOutput("single_idle_cfg", bus.rdwr_config, 2'b00);
      checkOutput("single_hold_addr", bus.reg_addr1, 5'd5);

      // Dual drain of distinct addresses
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 1'b0);
      applyStimulus(1'b1, 5'd4, 32'h22, 1'b1, 5'd4, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 1'b0);
      checkOutput("dual_cfg", bus.rdwr_config, 2'b11);
      checkOutput("dual_addr1", bus.reg_addr1, 5'd3);
      checkOutput("dual_addr2", bus.reg_addr2, 5'd4);
      drainIdle(2);

      // Same-address pair is serialized on port 1
      applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 1'b0);
      applyStimulus(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 1'b0);
      checkOutput("same_first_cfg", bus.rdwr_config, 2'b01);
      checkOutput("same_first_data", bus.wr_data1, 32'hA);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 1'b0);
      checkOutput("same_second_cfg", bus.rdwr_config, 2'b01);
      checkOutput("same_second_data", bus.wr_data1, 32'hB);
      drainIdle(1);

      // Fill under stall, fifth offer refused until a drain
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'd11, 1'b0);
      checkOutput("full_ready", bus.in_ready, 1'b0);
      applyStimulus(1'b1, 5'd14, 32'd104, 1'b1, 5'd14, 1'b0);
      applyStimulus(1'b1, 5'd14, 32'd104, 1'b0, 5'd12, 1'b0);
      applyStimulus(1'b1, 5'd14, 32'd104, 1'b0, 5'd14, 1'b0);
      drainIdle(4);

      // Writes to x0 are counted and saturate
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 5'd0, $urandom, 1'b0, 5'd0, 1'b0);
      checkOutput("x0_sat", bus.x0_drop_cnt, 8'd255);
      checkOutput("x0_cfg", bus.rdwr_config, 2'b00);

      // Reset with entries still buffered
      applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 5'd21, 32'h21, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 5'd22, 32'h22, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b1);
      checkOutput("rst_mid_cfg", bus.rdwr_config, 2'b00);
      checkOutput("rst_mid_data1", bus.wr_data1, 32'd0);
      checkOutput("rst_mid_drop", bus.x0_drop_cnt, 8'd0);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 1'b0);
      checkOutput("rst_mid_nowrite", bus.rdwr_config, 2'b00);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd22, 1'b0);

      // Random traffic with address collisions, stalls and rare resets
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 199) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
